// File: rtl/axis_switch_pkg.sv
// Shared types and sizing helpers for the AXI-Stream switch grant scheduler.
package axis_switch_pkg;

   typedef enum logic {
      SCH_IDLE   = 1'b0,
      SCH_LOCKED = 1'b1
   } sch_state_t;

   localparam int PORTS_DEFAULT = 4;

   function automatic int sel_width(input int ports);
      return (ports <= 2) ? 1 : $clog2(ports);
   endfunction

endpackage

// File: rtl/axis_switch_scheduler_if.sv
// Request/beat inputs and grant outputs exchanged between switch fabric and scheduler.
interface axis_switch_scheduler_if
   import axis_switch_pkg::*;
#(
   parameter int PORTS     = PORTS_DEFAULT,
   parameter int SEL_WIDTH = sel_width(PORTS)
);
   logic                         enable;
   logic [PORTS-1:0]             req_valid;
   logic [PORTS*SEL_WIDTH-1:0]   req_dest;
   logic [PORTS-1:0]             m_beat;
   logic [PORTS-1:0]             m_last;
   logic [PORTS-1:0]             grant_valid;
   logic [PORTS*SEL_WIDTH-1:0]   grant_src;
   logic [PORTS-1:0]             slave_busy;
   logic [PORTS-1:0]             timeout_pulse;

   modport slave (
      input  enable, req_valid, req_dest, m_beat, m_last,
      output grant_valid, grant_src, slave_busy, timeout_pulse
   );

   modport master (
      output enable, req_valid, req_dest, m_beat, m_last,
      input  grant_valid, grant_src, slave_busy, timeout_pulse
   );
endinterface

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module axis_rr_pick
   import axis_switch_pkg::*;
#(
   parameter int PORTS     = PORTS_DEFAULT,
   parameter int SEL_WIDTH = sel_width(PORTS)
) (
   input  logic [PORTS-1:0]     req,
   input  logic [SEL_WIDTH-1:0] ptr,
   output logic                 found,
   output logic [SEL_WIDTH-1:0] idx
);

   always_comb begin
      int p;
      found = 1'b0;
      idx   = '0;
      p     = 0;
      // Walk from the farthest offset down so the nearest one to ptr wins last.
      for (int k = PORTS - 1; k >= 0; k--) begin
         p = int'(ptr) + k;
         if (p >= PORTS) p = p - PORTS;
         if (req[p]) begin
            found = 1'b1;
            idx   = SEL_WIDTH'(p);
         end
      end
   end

endmodule

// File: rtl/axis_switch_scheduler.sv
// Per-master packet-lock grant scheduler with round-robin fairness and stall watchdog.
module axis_switch_scheduler
   import axis_switch_pkg::*;
#(
   parameter int PORTS         = PORTS_DEFAULT,
   parameter int SEL_WIDTH     = sel_width(PORTS),
   parameter int STALL_TIMEOUT = 255,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                    clk,
   input  logic                    resn,
   axis_switch_scheduler_if.slave  bus
);

   localparam logic [CNT_WIDTH-1:0] TIMEOUT = CNT_WIDTH'(STALL_TIMEOUT);

   sch_state_t           state_q [PORTS];
   sch_state_t           state_d [PORTS];
   logic [SEL_WIDTH-1:0] ptr_q   [PORTS];
   logic [SEL_WIDTH-1:0] ptr_d   [PORTS];
   logic [SEL_WIDTH-1:0] src_q   [PORTS];
   logic [SEL_WIDTH-1:0] src_d   [PORTS];
   logic [CNT_WIDTH-1:0] wd_q    [PORTS];
   logic [CNT_WIDTH-1:0] wd_d    [PORTS];
   logic [PORTS-1:0]     busy_q, busy_d, tmo_q, tmo_d;

   logic [PORTS-1:0]     rel_done, rel_tmo, rel_slaves, busy_eff;
   logic [PORTS-1:0]     cand    [PORTS];
   logic                 found   [PORTS];
   logic [SEL_WIDTH-1:0] win     [PORTS];

   // Slaves released this cycle may be re-granted in the same cycle.
   always_comb begin
      rel_done   = '0;
      rel_tmo    = '0;
      rel_slaves = '0;
      for (int j = 0; j < PORTS; j++) begin
         if (state_q[j] == SCH_LOCKED) begin
            rel_done[j] = bus.m_beat[j] & bus.m_last[j];
            rel_tmo[j]  = (STALL_TIMEOUT != 0) && (wd_q[j] == TIMEOUT) && !rel_done[j];
            if (rel_done[j] || rel_tmo[j]) rel_slaves[src_q[j]] = 1'b1;
         end
      end
      busy_eff = busy_q & ~rel_slaves;
   end

   always_comb begin
      for (int j = 0; j < PORTS; j++) begin
         for (int i = 0; i < PORTS; i++) begin
            cand[j][i] = bus.req_valid[i] && !busy_eff[i] &&
                         (int'(bus.req_dest[i*SEL_WIDTH +: SEL_WIDTH]) == j);
         end
      end
   end

   for (genvar g = 0; g < PORTS; g++) begin : g_pick
      axis_rr_pick #(
         .PORTS     (PORTS),
         .SEL_WIDTH (SEL_WIDTH)
      ) u_pick (
         .req   (cand[g]),
         .ptr   (ptr_q[g]),
         .found (found[g]),
         .idx   (win[g])
      );
   end

   always_comb begin
      busy_d = busy_eff;
      tmo_d  = rel_tmo;
      for (int j = 0; j < PORTS; j++) begin
         state_d[j] = state_q[j];
         ptr_d[j]   = ptr_q[j];
         src_d[j]   = src_q[j];
         wd_d[j]    = wd_q[j];
         if (state_q[j] == SCH_IDLE || rel_done[j] || rel_tmo[j]) begin
            if (bus.enable && found[j]) begin
               state_d[j]     = SCH_LOCKED;
               src_d[j]       = win[j];
               ptr_d[j]       = (win[j] == SEL_WIDTH'(PORTS - 1)) ? '0 : win[j] + SEL_WIDTH'(1);
               wd_d[j]        = '0;
               busy_d[win[j]] = 1'b1;
            end else begin
               state_d[j] = SCH_IDLE;
               src_d[j]   = '0;
               wd_d[j]    = '0;
            end
         end else if (bus.m_beat[j]) begin
            wd_d[j] = '0;
         end else if (wd_q[j] != TIMEOUT) begin
            wd_d[j] = wd_q[j] + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resn) begin
      if (!resn) begin
         busy_q <= '0;
         tmo_q  <= '0;
         for (int j = 0; j < PORTS; j++) begin
            state_q[j] <= SCH_IDLE;
            ptr_q[j]   <= '0;
            src_q[j]   <= '0;
            wd_q[j]    <= '0;
         end
      end else begin
         busy_q <= busy_d;
         tmo_q  <= tmo_d;
         for (int j = 0; j < PORTS; j++) begin
            state_q[j] <= state_d[j];
            ptr_q[j]   <= ptr_d[j];
            src_q[j]   <= src_d[j];
            wd_q[j]    <= wd_d[j];
         end
      end
   end

   always_comb begin
      bus.slave_busy    = busy_q;
      bus.timeout_pulse = tmo_q;
      bus.grant_valid   = '0;
      bus.grant_src     = '0;
      for (int j = 0; j < PORTS; j++) begin
         bus.grant_valid[j]                       = (state_q[j] == SCH_LOCKED);
         bus.grant_src[j*SEL_WIDTH +: SEL_WIDTH]  = src_q[j];
      end
   end

endmodule

// File: tb/tb_axis_switch_scheduler.sv
// Directed-vector bench for axis_switch_scheduler with a queue-based output scoreboard.
module tb_axis_switch_scheduler;
   import axis_switch_pkg::*;

   typedef struct {
      string       name;
      logic [19:0] exp;
   } exp_t;

   logic clk;
   logic resn;
   int   pass_cnt;
   int   total_cnt;
   exp_t exp_q[$];

   axis_switch_scheduler_if #(.PORTS(4), .SEL_WIDTH(2)) bus ();

   axis_switch_scheduler #(
      .PORTS         (4),
      .SEL_WIDTH     (2),
      .STALL_TIMEOUT (4),
      .CNT_WIDTH     (8)
   ) dut (
      .clk  (clk),
      .resn (resn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [19:0] snap(input logic [3:0] gv, input logic [1:0] s0,
                                        input logic [1:0] s1, input logic [1:0] s2,
                                        input logic [1:0] s3, input logic [3:0] busy,
                                        input logic [3:0] tp);
      return {tp, busy, s3, s2, s1, s0, gv};
   endfunction

   function automatic logic [7:0] dst(input logic [1:0] d0, input logic [1:0] d1,
                                      input logic [1:0] d2, input logic [1:0] d3);
      return {d3, d2, d1, d0};
   endfunction

   function automatic logic [19:0] actual();
      return {bus.timeout_pulse, bus.slave_busy, bus.grant_src, bus.grant_valid};
   endfunction

   function automatic void check(input string name, input logic [19:0] act, input logic [19:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got tp=%b busy=%b src=%h gv=%b, want tp=%b busy=%b src=%h gv=%b",
                    name, act[19:16], act[15:12], act[11:4], act[3:0],
                    exp[19:16], exp[15:12], exp[11:4], exp[3:0]);
   endfunction

   task automatic step(input string name, input logic en, input logic [3:0] rv,
                       input logic [7:0] rd, input logic [3:0] mb, input logic [3:0] ml,
                       input logic [19:0] e);
      exp_t item;
      @(negedge clk);
      bus.enable    = en;
      bus.req_valid = rv;
      bus.req_dest  = rd;
      bus.m_beat    = mb;
      bus.m_last    = ml;
      item.name     = name;
      item.exp      = e;
      exp_q.push_back(item);
   endtask

   // Monitor: compares the registered outputs just after each edge that has an expectation.
   initial begin
      exp_t item;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            item = exp_q.pop_front();
            check(item.name, actual(), item.exp);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL time_limit: simulation did not finish, want finish before 100000");
      $fatal(1, "time limit");
   end

   initial begin
      logic [19:0] lk;
      pass_cnt      = 0;
      total_cnt     = 0;
      resn          = 1'b0;
      bus.enable    = 1'b0;
      bus.req_valid = '0;
      bus.req_dest  = '0;
      bus.m_beat    = '0;
      bus.m_last    = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", actual(), 20'h0);
      @(negedge clk);
      resn = 1'b1;

      // Single 3-beat packet, slave 2 -> master 1.
      lk = snap(4'b0010, 2'd0, 2'd2, 2'd0, 2'd0, 4'b0100, 4'b0000);
      step("sp_grant", 1'b1, 4'b0100, dst(0, 0, 1, 0), 4'b0000, 4'b0000, lk);
      step("sp_beat1", 1'b1, 4'b0100, dst(0, 0, 1, 0), 4'b0010, 4'b0000, lk);
      step("sp_beat2", 1'b1, 4'b0100, dst(0, 0, 1, 0), 4'b0010, 4'b0000, lk);
      step("sp_last",  1'b1, 4'b0000, dst(0, 0, 1, 0), 4'b0010, 4'b0010, 20'h0);
      step("sp_idle",  1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000, 20'h0);

      // Fairness on master 0 among slaves 0,1,3 with 1-beat packets.
      step("rr_g0", 1'b1, 4'b1011, 8'h00, 4'b0000, 4'b0000, snap(4'b0001, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0001, 4'b0000));
      step("rr_g1", 1'b1, 4'b1011, 8'h00, 4'b0001, 4'b0001, snap(4'b0001, 2'd1, 2'd0, 2'd0, 2'd0, 4'b0010, 4'b0000));
      step("rr_g3", 1'b1, 4'b1011, 8'h00, 4'b0001, 4'b0001, snap(4'b0001, 2'd3, 2'd0, 2'd0, 2'd0, 4'b1000, 4'b0000));
      step("rr_g0b", 1'b1, 4'b1011, 8'h00, 4'b0001, 4'b0001, snap(4'b0001, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0001, 4'b0000));
      step("rr_g1b", 1'b1, 4'b1011, 8'h00, 4'b0001, 4'b0001, snap(4'b0001, 2'd1, 2'd0, 2'd0, 2'd0, 4'b0010, 4'b0000));
      step("rr_g3b", 1'b1, 4'b1011, 8'h00, 4'b0001, 4'b0001, snap(4'b0001, 2'd3, 2'd0, 2'd0, 2'd0, 4'b1000, 4'b0000));
      step("rr_end", 1'b1, 4'b0000, 8'h00, 4'b0001, 4'b0001, 20'h0);

      // Parallel: slave 0 -> master 3, slave 3 -> master 0.
      step("par_grant", 1'b1, 4'b1001, dst(3, 0, 0, 0), 4'b0000, 4'b0000, snap(4'b1001, 2'd3, 2'd0, 2'd0, 2'd0, 4'b1001, 4'b0000));
      step("par_last",  1'b1, 4'b0000, dst(3, 0, 0, 0), 4'b1001, 4'b1001, 20'h0);

      // Watchdog (timeout 4): slave 1 locked on master 2, one beat restarts the count.
      lk = snap(4'b0100, 2'd0, 2'd0, 2'd1, 2'd0, 4'b0010, 4'b0000);
      step("wd_grant", 1'b1, 4'b0010, dst(0, 2, 0, 0), 4'b0000, 4'b0000, lk);
      for (int k = 0; k < 3; k++)
         step($sformatf("wd_idle_a%0d", k), 1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000, lk);
      step("wd_beat", 1'b1, 4'b0000, 8'h00, 4'b0100, 4'b0000, lk);
      for (int k = 0; k < 4; k++)
         step($sformatf("wd_idle_b%0d", k), 1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000, lk);
      step("wd_fire",  1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000, snap(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000, 4'b0100));
      step("wd_after", 1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000, 20'h0);

      // Enable gating, then enable dropped mid-packet.
      lk = snap(4'b0010, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0001, 4'b0000);
      step("en_off1",  1'b0, 4'b0001, dst(1, 0, 0, 0), 4'b0000, 4'b0000, 20'h0);
      step("en_off2",  1'b0, 4'b0001, dst(1, 0, 0, 0), 4'b0000, 4'b0000, 20'h0);
      step("en_grant", 1'b1, 4'b0001, dst(1, 0, 0, 0), 4'b0000, 4'b0000, lk);
      step("en_hold",  1'b0, 4'b0001, dst(1, 0, 0, 0), 4'b0010, 4'b0000, lk);
      step("en_last",  1'b0, 4'b0001, dst(1, 0, 0, 0), 4'b0010, 4'b0010, 20'h0);
      step("en_stay",  1'b0, 4'b0001, dst(1, 0, 0, 0), 4'b0000, 4'b0000, 20'h0);

      // Async reset mid-packet, then pointer restarts from 0.
      lk = snap(4'b1000, 2'd0, 2'd0, 2'd0, 2'd2, 4'b0100, 4'b0000);
      step("rs_grant", 1'b1, 4'b0100, dst(0, 0, 3, 0), 4'b0000, 4'b0000, lk);
      step("rs_beat",  1'b1, 4'b0100, dst(0, 0, 3, 0), 4'b1000, 4'b0000, lk);
      @(posedge clk);
      #3;
      bus.req_valid = '0;
      bus.m_beat    = '0;
      bus.m_last    = '0;
      resn          = 1'b0;
      #1;
      check("async_reset", actual(), 20'h0);
      @(posedge clk);
      @(negedge clk);
      resn = 1'b1;
      step("rs_idle", 1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000, 20'h0);
      step("rs_ptr",  1'b1, 4'b1010, dst(0, 3, 0, 3), 4'b0000, 4'b0000, snap(4'b1000, 2'd0, 2'd0, 2'd0, 2'd1, 4'b0010, 4'b0000));
      step("rs_next", 1'b1, 4'b1000, dst(0, 3, 0, 3), 4'b1000, 4'b1000, snap(4'b1000, 2'd0, 2'd0, 2'd0, 2'd3, 4'b1000, 4'b0000));
      step("rs_end",  1'b1, 4'b0000, dst(0, 3, 0, 3), 4'b1000, 4'b1000, 20'h0);

      repeat (3) @(posedge clk);
      #2;
      total_cnt++;
      if (exp_q.size() == 0) pass_cnt++;
      else $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
